// File: rtl/sram_io_bridge.sv
// sram_io_bridge: sequences external 16-bit SRAM reads/writes from the LC-3 memory strobes
// and maps a single I/O address onto the board switches (read) and hex display (write).
// Optional build macro: IO_SWITCH_SYNC_EN adds a 2-flop synchronizer on Switches.
module sram_io_bridge #(
  parameter int unsigned WAIT_STATES = 0,
  parameter logic [15:0] IO_ADDR     = 16'hFFFF,
  parameter int unsigned SRAM_AW     = 20
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Mem_CE,
  input  logic               Mem_OE,
  input  logic               Mem_WE,
  input  logic               Mem_UB,
  input  logic               Mem_LB,
  input  logic [15:0]        ADDR,
  input  logic [15:0]        Data_from_CPU,
  output logic [15:0]        Data_to_CPU,
  output logic               Mem_Ready,
  output logic               Busy,
  input  logic [15:0]        Switches,
  output logic [15:0]        HEX_Data,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  output logic               SRAM_CE_N,
  output logic               SRAM_OE_N,
  output logic               SRAM_WE_N,
  output logic               SRAM_UB_N,
  output logic               SRAM_LB_N,
  input  logic [15:0]        SRAM_DQ_in,
  output logic [15:0]        SRAM_DQ_out,
  output logic               SRAM_DQ_oe
);

  localparam logic [2:0] WaitCnt = 3'(WAIT_STATES);

  typedef enum logic [2:0] {StIdle, StRd, StRdHold, StWrPulse, StWrHold} state_e;

  state_e      state_q, state_d;
  logic [2:0]  wcnt_q, wcnt_d;
  logic [15:0] rdata_q, rdata_d;
  logic [15:0] hex_q, hex_d;
  logic [15:0] waddr_q, waddr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        rd_io_q, rd_io_d;
  logic [15:0] sw_val;

  logic rd_req, wr_req, io_hit, wait_done;

  assign rd_req    = !Mem_CE && !Mem_OE && Mem_WE;
  assign wr_req    = !Mem_CE && !Mem_WE;
  assign io_hit    = (ADDR == IO_ADDR);
  assign wait_done = (wcnt_q == WaitCnt);

`ifdef IO_SWITCH_SYNC_EN
  logic [15:0] sw_meta_q, sw_sync_q;

  // Two-flop synchronizer for the asynchronous board switches.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sw_meta_q <= '0;
      sw_sync_q <= '0;
    end else begin
      sw_meta_q <= Switches;
      sw_sync_q <= sw_meta_q;
    end
  end

  assign sw_val = sw_sync_q;
`else
  assign sw_val = Switches;
`endif

  // State register and datapath latches.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= StIdle;
      wcnt_q  <= '0;
      rdata_q <= '0;
      hex_q   <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      rd_io_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      rdata_q <= rdata_d;
      hex_q   <= hex_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      rd_io_q <= rd_io_d;
    end
  end

  // Next-state logic: accept requests only in idle, count wait states, latch results.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    rdata_d = rdata_q;
    hex_d   = hex_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    rd_io_d = rd_io_q;
    unique case (state_q)
      StIdle: begin
        if (wr_req) begin
          if (io_hit) begin
            hex_d   = Data_from_CPU;
            state_d = StWrHold;
          end else begin
            waddr_d = ADDR;
            wdata_d = Data_from_CPU;
            state_d = StWrPulse;
          end
        end else if (rd_req) begin
          rd_io_d = io_hit;
          state_d = StRd;
        end
      end
      StRd: begin
        if (rd_io_q) begin
          rdata_d = sw_val;
          state_d = StRdHold;
        end else if (wait_done) begin
          rdata_d = SRAM_DQ_in;
          state_d = StRdHold;
        end else begin
          wcnt_d = wcnt_q + 3'd1;
        end
      end
      StRdHold: begin
        if (!rd_req) state_d = StIdle;
      end
      StWrPulse: begin
        if (wait_done) state_d = StWrHold;
        else           wcnt_d  = wcnt_q + 3'd1;
      end
      StWrHold: begin
        // Non-zero count marks that the ready pulse has already been given.
        if (!wr_req) state_d = StIdle;
        else         wcnt_d  = 3'd1;
      end
      default: state_d = StIdle;
    endcase
    if (state_d != state_q) wcnt_d = '0;
  end

  // Output decode; WE_N and OE_N can never be low together since only idle/read drive OE_N.
  always_comb begin
    SRAM_OE_N   = 1'b1;
    SRAM_WE_N   = 1'b1;
    SRAM_DQ_oe  = 1'b0;
    Mem_Ready   = 1'b0;
    Data_to_CPU = rdata_q;
    SRAM_ADDR   = SRAM_AW'(ADDR);
    unique case (state_q)
      StIdle: begin
        if (rd_req && !io_hit) SRAM_OE_N = 1'b0;
      end
      StRd: begin
        SRAM_OE_N   = rd_io_q;
        Mem_Ready   = rd_io_q || wait_done;
        Data_to_CPU = rd_io_q ? sw_val : SRAM_DQ_in;
      end
      StRdHold: ;
      StWrPulse: begin
        SRAM_WE_N  = 1'b0;
        SRAM_DQ_oe = 1'b1;
        SRAM_ADDR  = SRAM_AW'(waddr_q);
      end
      StWrHold: begin
        SRAM_DQ_oe = 1'b1;
        SRAM_ADDR  = SRAM_AW'(waddr_q);
        Mem_Ready  = (wcnt_q == 3'd0);
      end
      default: ;
    endcase
  end

  assign Busy        = (state_q != StIdle);
  assign HEX_Data    = hex_q;
  assign SRAM_DQ_out = wdata_q;
  assign SRAM_CE_N   = Mem_CE;
  assign SRAM_UB_N   = Mem_UB;
  assign SRAM_LB_N   = Mem_LB;

endmodule
